mem_access_ctrl: RTL and testbench

Request sequencer directly upstream of the one-hot word-line decoder. It accepts single-word read/write requests over a valid/ready handshake and drives the decoder `address`/`en` inputs for a fixed number of cycles. It strobes the array write enable, captures array read data after a fixed read latency, and returns it on a valid/ready response channel. Only one access is in flight at a time.

---
 rtl/mem_access_ctrl.sv | 91 +++++++++
 tb/tb_mem_access_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Single-outstanding read/write sequencer driving a word-line decoder and array.
// Accepts requests on a valid/ready handshake and returns read data on a response channel.
module mem_access_ctrl #(
  parameter int N      = 4,
  parameter int W      = 8,
  parameter int RD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [N-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  output logic [N-1:0] dec_address,
  output logic         dec_en,
  output logic         arr_we,
  output logic [W-1:0] arr_wdata,
  input  logic [W-1:0] arr_rdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_rdata,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] cnt;

  assign req_ready = (state == IDLE);

  // Outputs are set one edge ahead so the array sees glitch-free, registered controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dec_address <= '0;
      dec_en      <= 1'b0;
      arr_we      <= 1'b0;
      arr_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            dec_address <= req_addr;
            arr_wdata   <= req_wdata;
            dec_en      <= 1'b1;
            arr_we      <= req_we;
            cnt         <= 3'(RD_LAT - 1);
            busy        <= 1'b1;
            state       <= req_we ? WRITE : READ;
          end
        end
        WRITE: begin
          dec_en <= 1'b0;
          arr_we <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        READ: begin
          if (cnt == 3'd0) begin
            rsp_rdata <= arr_rdata;
            rsp_valid <= 1'b1;
            dec_en    <= 1'b0;
            state     <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small array model behind the decoder port.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_access_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic [3:0] dec_address;
  logic       dec_en;
  logic       arr_we;
  logic [7:0] arr_wdata;
  logic [7:0] arr_rdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];

  mem_access_ctrl #(.N(4), .W(8), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .dec_address(dec_address), .dec_en(dec_en), .arr_we(arr_we),
    .arr_wdata(arr_wdata), .arr_rdata(arr_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: word 9 preloads to 0x3C, writes land on the strobed edge.
  assign arr_rdata = mem[dec_address];
  always @(posedge clk) begin
    if (rst) mem[9] <= 8'h3C;
    else if (dec_en && arr_we) mem[dec_address] <= arr_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flags are {dec_en, arr_we, req_ready, rsp_valid, busy}.
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({dec_en, arr_we, req_ready, rsp_valid, busy} !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b exp %b", {dec_en, arr_we, req_ready, rsp_valid, busy}, 5'b00100);
    end
    checks++;
    if ({dec_address, arr_wdata, rsp_rdata} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h exp %h", {dec_address, arr_wdata, rsp_rdata}, 20'h0);
    end
  endtask

  task automatic test_write();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 8'hA5;
    step();
    req_valid = 1'b0;
    checks++;
    if ({dec_en, arr_we, req_ready, rsp_valid, busy} !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL wr_t1_flags got %b exp %b", {dec_en, arr_we, req_ready, rsp_valid, busy}, 5'b11001);
    end
    checks++;
    if ({dec_address, arr_wdata} !== {4'd5, 8'hA5}) begin
      errors++;
      $display("[TB] FAIL wr_t1_addr_data got %h exp %h", {dec_address, arr_wdata}, {4'd5, 8'hA5});
    end
    step();
    checks++;
    if ({dec_en, arr_we, req_ready, rsp_valid, busy} !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL wr_t2_flags got %b exp %b", {dec_en, arr_we, req_ready, rsp_valid, busy}, 5'b00100);
    end
  endtask

  task automatic test_read();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      checks++;
      if ({dec_en, arr_we, rsp_valid, dec_address} !== {3'b100, 4'd9}) begin
        errors++;
        $display("[TB] FAIL rd_t%0d_word got %b exp %b", k, {dec_en, arr_we, rsp_valid, dec_address}, {3'b100, 4'd9});
      end
      if (k == 1) step();
    end
    step();
    checks++;
    if ({dec_en, rsp_valid, req_ready, rsp_rdata} !== {3'b010, 8'h3C}) begin
      errors++;
      $display("[TB] FAIL rd_t3_rsp got %h exp %h", {dec_en, rsp_valid, req_ready, rsp_rdata}, {3'b010, 8'h3C});
    end
    step();
    checks++;
    if ({req_ready, rsp_valid, busy} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL rd_t4_idle got %b exp %b", {req_ready, rsp_valid, busy}, 3'b100);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
    step();
    req_addr = 4'd3;
    step();
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if ({rsp_valid, req_ready, dec_en, rsp_rdata, dec_address} !== {3'b100, 8'h3C, 4'd9}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d got %h exp %h", k, {rsp_valid, req_ready, dec_en, rsp_rdata, dec_address}, {3'b100, 8'h3C, 4'd9});
      end
    end
    rsp_ready = 1'b1;
    req_addr = 4'd5;
    step();
    checks++;
    if ({rsp_valid, req_ready, dec_en} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL bp_release got %b exp %b", {rsp_valid, req_ready, dec_en}, 3'b010);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if ({dec_en, dec_address} !== {1'b1, 4'd5}) begin
      errors++;
      $display("[TB] FAIL bp_next_accept got %h exp %h", {dec_en, dec_address}, {1'b1, 4'd5});
    end
    step();
    step();
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("[TB] FAIL bp_next_rsp got %h exp %h", {rsp_valid, rsp_rdata}, {1'b1, 8'hA5});
    end
    step();
  endtask

  task automatic test_boundary();
    logic [3:0] addrs [2];
    logic [7:0] datas [2];
    addrs[0] = 4'd15; addrs[1] = 4'd0;
    datas[0] = 8'h11; datas[1] = 8'h22;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = addrs[i]; req_wdata = datas[i];
      step();
      req_valid = 1'b0;
      checks++;
      if ({arr_we, dec_address, arr_wdata} !== {1'b1, addrs[i], datas[i]}) begin
        errors++;
        $display("[TB] FAIL bnd_wr%0d got %h exp %h", i, {arr_we, dec_address, arr_wdata}, {1'b1, addrs[i], datas[i]});
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = addrs[i];
      step();
      req_valid = 1'b0;
      checks++;
      if ({dec_en, dec_address} !== {1'b1, addrs[i]}) begin
        errors++;
        $display("[TB] FAIL bnd_rd_addr%0d got %h exp %h", i, {dec_en, dec_address}, {1'b1, addrs[i]});
      end
      step();
      step();
      checks++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, datas[i]}) begin
        errors++;
        $display("[TB] FAIL bnd_rd_data%0d got %h exp %h", i, {rsp_valid, rsp_rdata}, {1'b1, datas[i]});
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({dec_en, arr_we, req_ready, rsp_valid, busy, dec_address, arr_wdata, rsp_rdata} !== {5'b00100, 20'h0}) begin
      errors++;
      $display("[TB] FAIL rst_read got %h exp %h", {dec_en, arr_we, req_ready, rsp_valid, busy, dec_address, arr_wdata, rsp_rdata}, {5'b00100, 20'h0});
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if ({rsp_valid, req_ready, dec_en} !== 3'b010) begin
        errors++;
        $display("[TB] FAIL rst_read_quiet%0d got %b exp %b", k, {rsp_valid, req_ready, dec_en}, 3'b010);
      end
    end
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
    step();
    req_valid = 1'b0;
    step();
    step();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_resp_pre got %b exp %b", rsp_valid, 1'b1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({dec_en, arr_we, req_ready, rsp_valid, busy, dec_address, arr_wdata, rsp_rdata} !== {5'b00100, 20'h0}) begin
      errors++;
      $display("[TB] FAIL rst_resp got %h exp %h", {dec_en, arr_we, req_ready, rsp_valid, busy, dec_address, arr_wdata, rsp_rdata}, {5'b00100, 20'h0});
    end
    step();
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rst_resp_after got %b exp %b", {rsp_valid, req_ready}, 2'b01);
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic prev_we;
    prev_we = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd2; req_wdata = 8'h50;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if ({arr_we, req_ready} !== {(k % 2) == 1, (k % 2) == 0}) begin
        errors++;
        $display("[TB] FAIL b2b_cycle%0d got %b exp %b", k, {arr_we, req_ready}, {(k % 2) == 1, (k % 2) == 0});
      end
      if ((k % 2) == 1) begin
        checks++;
        if (arr_wdata !== 8'(8'h50 + k - 1)) begin
          errors++;
          $display("[TB] FAIL b2b_wdata%0d got %h exp %h", k, arr_wdata, 8'(8'h50 + k - 1));
        end
      end
      checks++;
      if (prev_we && arr_we) begin
        errors++;
        $display("[TB] FAIL b2b_double_we%0d got %b exp %b", k, arr_we, 1'b0);
      end
      prev_we = arr_we;
      req_wdata = 8'(8'h50 + k);
    end
    req_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
